// File: rtl/fht_frame_sched.sv
// Frame scheduler around fht_control: owns the 4-bank sample memory through
// LOAD -> COMPUTE -> UNLOAD and drives the bank mux select and the loader and
// unloader addresses. Every output is registered.
module fht_frame_sched #(
  parameter int unsigned A_BIT  = 8,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned TO_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iEN,
  input  logic             iDATA_VALID,
  output logic             oDATA_READY,
  output logic             oLD_WE,
  output logic [1:0]       oLD_BANK,
  output logic [A_BIT-1:0] oLD_ADDR,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic             oUL_RE,
  output logic [1:0]       oUL_BANK,
  output logic [A_BIT-1:0] oUL_ADDR,
  output logic             oOUT_VALID,
  input  logic             iOUT_READY,
  output logic             oOUT_LAST,
  output logic [1:0]       oOWNER,
  output logic             oFRAME_DONE,
  output logic             oERR
);

  localparam int unsigned K_BIT = A_BIT + 2;
  localparam logic [K_BIT-1:0]  K_LAST    = '1;
  localparam logic [TO_BIT-1:0] TO_LAST   = '1;
  // Busy must be seen within 8 cycles counted from the START pulse:
  // START itself plus WAIT_BUSY cycles with count 0..6.
  localparam logic [TO_BIT-1:0] BUSY_LAST = TO_BIT'(6);
  // UNL_WAIT lasts RD_LAT-1 cycles so data is valid RD_LAT cycles after RE.
  localparam logic [TO_BIT-1:0] WAIT_LAST = TO_BIT'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_UNL_RD,
    S_UNL_WAIT,
    S_UNL_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [K_BIT-1:0]   k_q, k_d;
  logic [TO_BIT-1:0]  cnt_q, cnt_d;

  logic             ready_d, ld_we_d, start_d, re_d, valid_d, last_d, done_d, err_d;
  logic [1:0]       ld_bank_d, ul_bank_d, owner_d;
  logic [A_BIT-1:0] ld_addr_d, ul_addr_d;

  // Next state, sample counter, timeout counter and next registered outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    ld_we_d   = 1'b0;
    ld_bank_d = oLD_BANK;
    ld_addr_d = oLD_ADDR;
    ul_bank_d = oUL_BANK;
    ul_addr_d = oUL_ADDR;
    done_d    = 1'b0;
    err_d     = oERR;
    owner_d   = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (iEN) begin
          state_d = S_LOAD;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (iDATA_VALID) begin
          ld_we_d   = 1'b1;
          ld_bank_d = k_q[1:0];
          ld_addr_d = k_q[K_BIT-1:2];
          k_d       = k_q + K_BIT'(1);
          if (k_q == K_LAST) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (!iFHT_RDY) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == BUSY_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_BIT'(1);
        end
      end
      S_WAIT_DONE: begin
        if (iFHT_RDY) begin
          state_d = S_UNL_RD;
          k_d     = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_BIT'(1);
        end
      end
      S_UNL_RD: begin
        cnt_d   = '0;
        state_d = (RD_LAT > 1) ? S_UNL_WAIT : S_UNL_OUT;
      end
      S_UNL_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_UNL_OUT;
        else                    cnt_d   = cnt_q + TO_BIT'(1);
      end
      S_UNL_OUT: begin
        if (iOUT_READY) begin
          if (k_q == K_LAST) begin
            done_d = 1'b1;
            k_d    = '0;
            if (iEN) begin
              state_d = S_LOAD;
              err_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            k_d     = k_q + K_BIT'(1);
            state_d = S_UNL_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read address is presented together with the RE strobe.
    if (state_d == S_UNL_RD) begin
      ul_bank_d = k_d[1:0];
      ul_addr_d = k_d[K_BIT-1:2];
    end

    ready_d = (state_d == S_LOAD);
    start_d = (state_d == S_START);
    re_d    = (state_d == S_UNL_RD);
    valid_d = (state_d == S_UNL_OUT);
    last_d  = valid_d && (k_d == K_LAST);

    case (state_d)
      S_LOAD, S_START:                     owner_d = 2'd1;
      S_WAIT_BUSY, S_WAIT_DONE:            owner_d = 2'd2;
      S_UNL_RD, S_UNL_WAIT, S_UNL_OUT:     owner_d = 2'd3;
      default:                             owner_d = 2'd0;
    endcase
  end

  // State, counters and output registers; reset aborts any frame in flight.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      oDATA_READY <= 1'b0;
      oLD_WE      <= 1'b0;
      oLD_BANK    <= '0;
      oLD_ADDR    <= '0;
      oFHT_START  <= 1'b0;
      oUL_RE      <= 1'b0;
      oUL_BANK    <= '0;
      oUL_ADDR    <= '0;
      oOUT_VALID  <= 1'b0;
      oOUT_LAST   <= 1'b0;
      oOWNER      <= '0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      oDATA_READY <= ready_d;
      oLD_WE      <= ld_we_d;
      oLD_BANK    <= ld_bank_d;
      oLD_ADDR    <= ld_addr_d;
      oFHT_START  <= start_d;
      oUL_RE      <= re_d;
      oUL_BANK    <= ul_bank_d;
      oUL_ADDR    <= ul_addr_d;
      oOUT_VALID  <= valid_d;
      oOUT_LAST   <= last_d;
      oOWNER      <= owner_d;
      oFRAME_DONE <= done_d;
      oERR        <= err_d;
    end
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Scoreboard bench for fht_frame_sched: the stimulus side pushes the expected
// write/read/output index sequence, a negedge monitor pops and compares.
module tb_fht_frame_sched;

  localparam int unsigned A_BIT   = 2;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned TO_BIT  = 6;
  localparam int unsigned N       = 4 * (1 << A_BIT);
  localparam int unsigned DONE_TO = (1 << TO_BIT) - 1;

  logic clk = 1'b0;
  logic iRESET, iEN, iDATA_VALID, iFHT_RDY, iOUT_READY;
  logic oDATA_READY, oLD_WE, oFHT_START, oUL_RE, oOUT_VALID, oOUT_LAST, oFRAME_DONE, oERR;
  logic [1:0]       oLD_BANK, oUL_BANK, oOWNER;
  logic [A_BIT-1:0] oLD_ADDR, oUL_ADDR;
  logic [17:0]      all_outs;

  typedef struct {
    int unsigned bank;
    int unsigned addr;
    bit          last;
  } exp_t;

  exp_t we_q[$];
  exp_t re_q[$];
  exp_t out_q[$];

  int unsigned n_cmp    = 0;
  int unsigned n_bad    = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;

  fht_frame_sched #(.A_BIT(A_BIT), .RD_LAT(RD_LAT), .TO_BIT(TO_BIT)) dut (
    .iCLK(clk), .iRESET(iRESET), .iEN(iEN), .iDATA_VALID(iDATA_VALID),
    .oDATA_READY(oDATA_READY), .oLD_WE(oLD_WE), .oLD_BANK(oLD_BANK), .oLD_ADDR(oLD_ADDR),
    .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY), .oUL_RE(oUL_RE), .oUL_BANK(oUL_BANK),
    .oUL_ADDR(oUL_ADDR), .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY),
    .oOUT_LAST(oOUT_LAST), .oOWNER(oOWNER), .oFRAME_DONE(oFRAME_DONE), .oERR(oERR)
  );

  assign all_outs = {oDATA_READY, oLD_WE, oLD_BANK, oLD_ADDR, oFHT_START, oUL_RE, oUL_BANK,
                     oUL_ADDR, oOUT_VALID, oOUT_LAST, oOWNER, oFRAME_DONE, oERR};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got cycle %0d, required finish before %0d", cyc, 40000);
    $fatal(1, "watchdog expired");
  end

  // Sample index j lives in bank j mod 4 at in-bank address j div 4.
  function automatic exp_t idx_map(input int unsigned j);
    exp_t e;
    e.bank = j % 4;
    e.addr = j / 4;
    e.last = (j == N - 1);
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_noise();
    iDATA_VALID = 1'($urandom_range(0, 1));
    step();
  endtask

  // Stream one frame in; mode 0 valid held, 1 toggling, 2 random.
  task automatic load_frame(input int mode);
    int unsigned j = 0;
    int unsigned b = 0;
    int unsigned first_acc = 0;
    bit v;
    while (j < N && b < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (b % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      iDATA_VALID = v;
      if (v && oDATA_READY) begin
        if (j == 0) first_acc = cyc;
        we_q.push_back(idx_map(j));
        j++;
        last_acc = cyc;
      end
      step();
      b++;
    end
    iDATA_VALID = 1'b0;
    check("load_complete", j, N);
    if (mode == 0) check("load_back_to_back", last_acc - first_acc, N - 1);
  endtask

  // Compute phase; mode 0 normal, 1 busy never seen, 2 done never seen.
  task automatic fht_phase(input int mode);
    int unsigned b = 0;
    while (!oFHT_START && b < 64) begin step(); b++; end
    check("start_seen", oFHT_START, 1);
    check("start_after_last_accept", cyc, last_acc + 1);
    check("start_owner", oOWNER, 1);
    check("start_with_last_we", oLD_WE, 1);
    step_noise();
    check("start_one_cycle", oFHT_START, 0);
    check("owner_wait_busy", oOWNER, 2);
    check("all_writes_seen", we_q.size(), 0);
    if (mode == 1) begin
      for (int i = 2; i <= 7; i++) begin
        step_noise();
        check("busy_owner", oOWNER, 2);
        check("busy_no_err", oERR, 0);
      end
      step_noise();
      check("busy_timeout_err", oERR, 1);
      check("busy_timeout_owner", oOWNER, 0);
      step_noise();
      check("err_sticky", oERR, 1);
    end else begin
      step_noise();
      step_noise();
      iFHT_RDY = 1'b0;
      if (mode == 0) begin
        for (int i = 0; i < 40; i++) begin
          step_noise();
          check("owner_fht", oOWNER, 2);
        end
        iFHT_RDY = 1'b1;
        for (int j = 0; j < N; j++) begin
          re_q.push_back(idx_map(j));
          out_q.push_back(idx_map(j));
        end
        step_noise();
        check("first_re_after_rdy", oUL_RE, 1);
        check("owner_unload", oOWNER, 3);
      end else begin
        for (int i = 0; i <= int'(DONE_TO); i++) begin
          step_noise();
          check("done_wait_owner", oOWNER, 2);
        end
        check("done_no_err_yet", oERR, 0);
        step_noise();
        check("done_timeout_err", oERR, 1);
        check("done_timeout_owner", oOWNER, 0);
        iFHT_RDY = 1'b1;
      end
    end
    iDATA_VALID = 1'b0;
  endtask

  // Drain outputs with random back-pressure until stop_after remain.
  task automatic unload_phase(input bit stall_k7, input int unsigned stop_after);
    int unsigned stalls = 0;
    int unsigned b = 0;
    while (out_q.size() > stop_after && b < 400) begin
      if (stall_k7 && oOUT_VALID && oUL_BANK == 2'd3 && oUL_ADDR == A_BIT'(1) && stalls < 5) begin
        iOUT_READY = 1'b0;
        stalls++;
      end else begin
        iOUT_READY = ($urandom_range(0, 3) != 0);
      end
      step();
      b++;
    end
    iOUT_READY = 1'b0;
    check("unload_progress", out_q.size() <= stop_after, 1);
    if (stall_k7) check("stall_cycles", stalls, 5);
  endtask

  // Monitor: pops expectations as the DUT strobes and checks hold/latency.
  exp_t             mon_e;
  bit               prev_stall = 1'b0;
  bit               re_pending = 1'b0;
  int unsigned      last_re    = 0;
  int unsigned      done_due   = 0;
  logic [1:0]       prev_bank;
  logic [A_BIT-1:0] prev_addr;

  always @(negedge clk) begin
    if (iRESET) begin
      prev_stall = 1'b0;
      re_pending = 1'b0;
      done_due   = 0;
    end else begin
      if (oLD_WE) begin
        if (we_q.size() == 0) check("we_spurious", 1, 0);
        else begin
          mon_e = we_q.pop_front();
          check("we_bank", oLD_BANK, mon_e.bank);
          check("we_addr", oLD_ADDR, mon_e.addr);
        end
      end
      if (oUL_RE) begin
        check("re_with_valid", oOUT_VALID, 0);
        if (re_q.size() == 0) check("re_spurious", 1, 0);
        else begin
          mon_e = re_q.pop_front();
          check("re_bank", oUL_BANK, mon_e.bank);
          check("re_addr", oUL_ADDR, mon_e.addr);
        end
        re_pending = 1'b1;
        last_re    = cyc;
      end
      if (prev_stall) begin
        check("valid_held", oOUT_VALID, 1);
        check("bank_held", oUL_BANK, prev_bank);
        check("addr_held", oUL_ADDR, prev_addr);
      end
      if (oOUT_VALID) begin
        if (re_pending) begin
          check("read_latency", cyc - last_re, RD_LAT);
          re_pending = 1'b0;
        end
        if (out_q.size() == 0) check("out_spurious", 1, 0);
        else begin
          check("out_last", oOUT_LAST, out_q[0].last);
          if (iOUT_READY) begin
            mon_e = out_q.pop_front();
            check("out_bank", oUL_BANK, mon_e.bank);
            check("out_addr", oUL_ADDR, mon_e.addr);
            if (mon_e.last) done_due = cyc + 1;
          end
        end
      end
      if (done_due != 0 && cyc == done_due) begin
        check("frame_done_pulse", oFRAME_DONE, 1);
        done_due = 0;
      end else if (oFRAME_DONE) begin
        check("frame_done_spurious", 1, 0);
      end
      prev_stall = oOUT_VALID && !iOUT_READY;
      prev_bank  = oUL_BANK;
      prev_addr  = oUL_ADDR;
    end
  end

  initial begin
    iRESET = 1'b1; iEN = 1'b0; iDATA_VALID = 1'b0; iFHT_RDY = 1'b1; iOUT_READY = 1'b0;
    repeat (3) step();
    check("reset_outputs", all_outs, 0);
    iRESET = 1'b0;
    repeat (3) step();
    check("idle_owner", oOWNER, 0);
    check("idle_ready", oDATA_READY, 0);

    // Frame 1: valid held, normal compute, stall at k=7, chain into next LOAD.
    iEN = 1'b1;
    step();
    check("load_owner", oOWNER, 1);
    check("load_ready", oDATA_READY, 1);
    load_frame(0);
    fht_phase(0);
    unload_phase(1'b1, 0);
    check("done_to_load_owner", oOWNER, 1);

    // Frame 2: toggling valid, busy timeout, next LOAD clears the error.
    load_frame(1);
    iEN = 1'b0;
    fht_phase(1);
    iEN = 1'b1;
    step();
    check("err_cleared_on_load", oERR, 0);
    check("reload_owner", oOWNER, 1);

    // Frame 3: random valid, compute-done timeout.
    load_frame(2);
    iEN = 1'b0;
    fht_phase(2);
    iEN = 1'b1;
    step();
    check("err_cleared_on_load2", oERR, 0);

    // Frame 4: random valid and back-pressure, ends in IDLE.
    load_frame(2);
    iEN = 1'b0;
    fht_phase(0);
    unload_phase(1'b0, 0);
    check("done_to_idle_owner", oOWNER, 0);

    // Frame 5: reset in the middle of unload.
    iEN = 1'b1;
    step();
    load_frame(2);
    fht_phase(0);
    unload_phase(1'b0, N - 6);
    iRESET = 1'b1;
    step();
    check("reset_mid_unload", all_outs, 0);
    re_q.delete();
    out_q.delete();
    iRESET = 1'b0;
    step();
    check("post_reset_owner", oOWNER, 1);

    // Frame 6: restarts at k=0 after the abort.
    load_frame(0);
    iEN = 1'b0;
    fht_phase(0);
    unload_phase(1'b0, 0);
    check("final_idle_owner", oOWNER, 0);
    step();
    check("queues_drained", we_q.size() + re_q.size() + out_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
